router_input_port: RTL and testbench

//   Clocked router input stage: buffers single-flit packets from one link, computes the
//   XY route of the head flit and presents it to exactly one of five per-direction output

---
 rtl/router_input_port.sv | 107 ++++++++++
 tb/tb_router_input_port.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_port.sv
// router_input_port: single-flit input buffer with XY route decode.
// Head flit requests exactly one output direction; U-turn flits are dropped.
module router_input_port #(
   parameter int WIDTH  = 39,
   parameter int DEPTH  = 4,
   parameter int MY_X   = 0,
   parameter int MY_Y   = 0,
   parameter int IN_DIR = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [4:0]       out_valid,
   input  logic [4:0]       out_ready,
   output logic             drop_err,
   output logic [7:0]       drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];
   localparam logic [3:0]  MX   = MY_X[3:0];
   localparam logic [3:0]  MYY  = MY_Y[3:0];
   localparam logic [2:0]  SELF = IN_DIR[2:0];

   localparam logic [2:0] DIR_N = 3'd0;
   localparam logic [2:0] DIR_E = 3'd1;
   localparam logic [2:0] DIR_S = 3'd2;
   localparam logic [2:0] DIR_W = 3'd3;
   localparam logic [2:0] DIR_L = 3'd4;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   logic       empty;
   logic       push;
   logic       pop;
   logic       uturn;
   logic       accept;
   logic [3:0] dx;
   logic [3:0] dy;
   logic [2:0] route;

   assign empty    = (count == '0);
   assign in_ready = (count != FULL);
   assign push     = in_valid & in_ready;

   assign out_data = mem[rd_ptr];
   assign dx       = out_data[WIDTH-1 -: 4];
   assign dy       = out_data[WIDTH-5 -: 4];

   // XY route of the head: x fully resolved before y
   always_comb begin
      route = DIR_L;
      priority case (1'b1)
         (dx > MX):  route = DIR_E;
         (dx < MX):  route = DIR_W;
         (dy > MYY): route = DIR_N;
         (dy < MYY): route = DIR_S;
         default:    route = DIR_L;
      endcase
   end

   assign uturn     = (route == SELF);
   assign out_valid = (!empty && !uturn) ? (5'b00001 << route) : 5'b00000;
   assign accept    = |(out_valid & out_ready);
   assign pop       = !empty & (uturn | accept);

   // flit storage, contents need no reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   // pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // drop pulse and saturating drop counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_err <= 1'b0;
         drop_cnt <= 8'd0;
      end else begin
         drop_err <= !empty & uturn;
         if (!empty && uturn && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_router_input_port.sv
// tb_router_input_port: randomized and directed checks of router_input_port
// against a queue-based reference model of the input buffer.
module tb_router_input_port;

   localparam int WIDTH  = 39;
   localparam int DEPTH  = 4;
   localparam int MY_X   = 1;
   localparam int MY_Y   = 1;
   localparam int IN_DIR = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic [4:0]       out_valid;
   logic [4:0]       out_ready = 5'b0;
   logic             drop_err;
   logic [7:0]       drop_cnt;

   int checks = 0;
   int failures = 0;

   logic [WIDTH-1:0] q[$];
   bit               e_drop = 0;
   int               e_cnt = 0;
   bit               last_pushed = 0;

   always #5 clk = ~clk;

   router_input_port #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .MY_X(MY_X), .MY_Y(MY_Y), .IN_DIR(IN_DIR)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .drop_err(drop_err), .drop_cnt(drop_cnt)
   );

   function automatic int dir_of(input logic [WIDTH-1:0] f);
      int x;
      int y;
      x = int'(f[WIDTH-1 -: 4]);
      y = int'(f[WIDTH-5 -: 4]);
      if (x != MY_X) return (x > MY_X) ? 1 : 3;
      if (y != MY_Y) return (y > MY_Y) ? 0 : 2;
      return 4;
   endfunction

   function automatic logic [4:0] exp_ov();
      if (q.size() == 0) return 5'b0;
      if (dir_of(q[0]) == IN_DIR) return 5'b0;
      return 5'(1 << dir_of(q[0]));
   endfunction

   function automatic logic [WIDTH-1:0] mk(input int x, input int y);
      logic [WIDTH-9:0] p;
      p = (WIDTH-8)'({$urandom, $urandom});
      return {4'(x), 4'(y), p};
   endfunction

   task automatic model_reset();
      q.delete();
      e_drop = 0;
      e_cnt = 0;
   endtask

   task automatic step(input logic v, input logic [WIDTH-1:0] d,
                       input logic [4:0] rdy);
      int r;
      bit pop;
      bit room;
      in_valid = v;
      in_data = d;
      out_ready = rdy;
      @(posedge clk);
      pop = 0;
      room = (q.size() < DEPTH);
      e_drop = 0;
      if (q.size() != 0) begin
         r = dir_of(q[0]);
         if (r == IN_DIR) begin
            pop = 1;
            e_drop = 1;
            if (e_cnt < 255) e_cnt++;
         end else if (rdy[r]) begin
            pop = 1;
         end
      end
      if (pop) void'(q.pop_front());
      last_pushed = v && room;
      if (last_pushed) q.push_back(d);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 5'h1F);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 5'b0) begin
         failures++;
         $display("FAIL reset_ov act=%b exp=%b", out_valid, 5'b0);
      end
      checks++;
      if (in_ready !== 1'b1 || drop_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_init act=rdy%b cnt%0d exp=rdy1 cnt0", in_ready, drop_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1'b1, mk(0, 1), 5'h00);
      step(1'b1, mk(2, 2), 5'h00);
      step(1'b1, mk(2, 2), 5'h00);
      checks++;
      if (drop_cnt !== 8'(e_cnt) || out_valid !== exp_ov()) begin
         failures++;
         $display("FAIL pre_reset act=cnt%0d ov%b exp=cnt%0d ov%b",
                  drop_cnt, out_valid, e_cnt, exp_ov());
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 5'b0 || drop_cnt !== 8'd0 ||
          in_ready !== 1'b1 || drop_err !== 1'b0) begin
         failures++;
         $display("FAIL async_reset act=ov%b cnt%0d rdy%b err%b exp=ov0 cnt0 rdy1 err0",
                  out_valid, drop_cnt, in_ready, drop_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1'b0, '0, 5'h1F);
      step(1'b0, '0, 5'h1F);
      checks++;
      if (out_valid !== 5'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset act=ov%b rdy%b exp=ov0 rdy1", out_valid, in_ready);
      end
   endtask

   task automatic test_routing();
      int xs[5] = '{2, 0, 1, 1, 1};
      int ys[5] = '{0, 3, 3, 0, 1};
      logic [4:0] lit[5] = '{5'b00010, 5'b00000, 5'b00001, 5'b00100, 5'b10000};
      logic [WIDTH-1:0] f;
      int cnt0;
      for (int i = 0; i < 5; i++) begin
         f = mk(xs[i], ys[i]);
         cnt0 = int'(drop_cnt);
         step(1'b1, f, 5'h00);
         checks++;
         if (out_valid !== lit[i] || out_valid !== exp_ov()) begin
            failures++;
            $display("FAIL route_%0d act=%b exp=%b", i, out_valid, lit[i]);
         end
         checks++;
         if (out_data !== f) begin
            failures++;
            $display("FAIL route_data_%0d act=%h exp=%h", i, out_data, f);
         end
         step(1'b0, '0, 5'h1F);
         checks++;
         if (drop_err !== (lit[i] == 5'b0) || out_valid !== 5'b0) begin
            failures++;
            $display("FAIL route_pop_%0d act=err%b ov%b exp=err%b ov0",
                     i, drop_err, out_valid, lit[i] == 5'b0);
         end
         if (lit[i] == 5'b0) begin
            checks++;
            if (int'(drop_cnt) != cnt0 + 1) begin
               failures++;
               $display("FAIL route_dropcnt act=%0d exp=%0d", drop_cnt, cnt0 + 1);
            end
         end
      end
   endtask

   task automatic test_fill();
      logic [WIDTH-1:0] f[5];
      bit pend;
      for (int i = 0; i < 5; i++) f[i] = mk(2, $urandom_range(0, 2));
      for (int i = 0; i < 5; i++) begin
         step(1'b1, f[i], 5'h00);
         checks++;
         if (in_ready !== (i < DEPTH - 1)) begin
            failures++;
            $display("FAIL fill_rdy_%0d act=%b exp=%b", i, in_ready, i < DEPTH - 1);
         end
      end
      pend = 1;
      for (int j = 0; j < 5; j++) begin
         checks++;
         if (out_valid !== 5'b00010 || out_data !== f[j]) begin
            failures++;
            $display("FAIL fill_order_%0d act=%b/%h exp=00010/%h",
                     j, out_valid, out_data, f[j]);
         end
         step(pend, f[4], 5'h1F);
         if (last_pushed) pend = 0;
      end
      checks++;
      if (out_valid !== 5'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL fill_empty act=ov%b rdy%b exp=ov0 rdy1", out_valid, in_ready);
      end
   endtask

   task automatic test_stream();
      logic [WIDTH-1:0] f;
      for (int i = 0; i < 40; i++) begin
         f = mk($urandom_range(1, 2), $urandom_range(0, 2));
         step(1'b1, f, 5'h1F);
         checks++;
         if (out_data !== f || out_valid !== exp_ov() || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stream_%0d act=%h/%b/%b exp=%h/%b/1",
                     i, out_data, out_valid, in_ready, f, exp_ov());
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] f;
      f = mk(3, $urandom_range(0, 3));
      step(1'b1, f, 5'h00);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid !== 5'b00010 || out_data !== f) begin
            failures++;
            $display("FAIL bp_hold_%0d act=%b/%h exp=00010/%h", i, out_valid, out_data, f);
         end
         step(1'b0, '0, 5'b11101);
      end
      step(1'b0, '0, 5'b00010);
      checks++;
      if (out_valid !== 5'b0) begin
         failures++;
         $display("FAIL bp_pop act=%b exp=00000", out_valid);
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] f;
      for (int i = 0; i < 300; i++) begin
         f = mk($urandom_range(0, 2), $urandom_range(0, 2));
         step(1'($urandom_range(0, 1)), f, 5'($urandom));
         checks++;
         if (out_valid !== exp_ov()) begin
            failures++;
            $display("FAIL rnd_ov_%0d act=%b exp=%b", i, out_valid, exp_ov());
         end
         if (q.size() != 0) begin
            checks++;
            if (out_data !== q[0]) begin
               failures++;
               $display("FAIL rnd_data_%0d act=%h exp=%h", i, out_data, q[0]);
            end
         end
         checks++;
         if (in_ready !== (q.size() < DEPTH) || drop_err !== e_drop ||
             drop_cnt !== 8'(e_cnt)) begin
            failures++;
            $display("FAIL rnd_ctl_%0d act=%b/%b/%0d exp=%b/%b/%0d", i,
                     in_ready, drop_err, drop_cnt, q.size() < DEPTH, e_drop, e_cnt);
         end
      end
      drain();
   endtask

   task automatic test_saturation();
      int pulses;
      pulses = 0;
      for (int i = 0; i < 302; i++) begin
         step(i < 300, mk(0, $urandom_range(0, 15)), 5'($urandom));
         if (drop_err === 1'b1) pulses++;
         checks++;
         if (drop_cnt !== 8'(e_cnt) || out_valid !== 5'b0) begin
            failures++;
            $display("FAIL sat_%0d act=cnt%0d ov%b exp=cnt%0d ov0",
                     i, drop_cnt, out_valid, e_cnt);
         end
      end
      checks++;
      if (drop_cnt !== 8'd255) begin
         failures++;
         $display("FAIL sat_final act=%0d exp=255", drop_cnt);
      end
      checks++;
      if (pulses != 300) begin
         failures++;
         $display("FAIL sat_pulses act=%0d exp=300", pulses);
      end
   endtask

   initial begin
      test_reset();
      test_routing();
      test_fill();
      test_stream();
      test_backpressure();
      test_random();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
